// File: rtl/buzzer_pkg.sv
// Shared definitions for the panel buzzer tone generator.
//   estado_t           : sequencer state encoding (OCIOSO/TOM/PAUSA/FIM)
//   meio_periodo_calc  : half-period in clock cycles of tone 'indice', clamped to >= 1
//   clog2_min1         : ceiling log2, never below 1 (safe as a vector width)
// Optional feature macro used by the top: BUZZER_PAUSA_EN.
package buzzer_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    TOM    = 2'd1,
    PAUSA  = 2'd2,
    FIM    = 2'd3
  } estado_t;

  // Tone i runs at base_hz*(i+1); a square wave needs two half periods per cycle.
  function automatic int unsigned meio_periodo_calc(input int unsigned clock_hz,
                                                    input int unsigned base_hz,
                                                    input int unsigned indice);
    int unsigned hp;
    hp = clock_hz / (2 * base_hz * (indice + 1));
    if (hp == 0) hp = 1;
    return hp;
  endfunction

  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/buzzer_multitom_divisor.sv
// Programmable half-period divider with toggle flop.
// Ports:
//   clock        in  system clock, rising edge
//   reset        in  synchronous, active-high
//   habilita     in  count enable; low clears counter and output
//   reinicia     in  restart request; clears counter and output on this edge
//   meio_periodo in  half period in cycles (>= 1)
//   pulso        out square wave, toggles each time the counter wraps
module buzzer_divisor #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         habilita,
  input  logic         reinicia,
  input  logic [W-1:0] meio_periodo,
  output logic         pulso
);

  logic [W-1:0] cont_q;
  logic         pulso_q;

  always_ff @(posedge clock) begin
    if (reset || reinicia || !habilita) begin
      cont_q  <= '0;
      pulso_q <= 1'b0;
    end else if (cont_q >= meio_periodo - W'(1)) begin
      // >= rather than == so a stale count above a new limit still wraps
      cont_q  <= '0;
      pulso_q <= ~pulso_q;
    end else begin
      cont_q  <= cont_q + W'(1);
    end
  end

  assign pulso = pulso_q;

endmodule

// File: rtl/buzzer_multitom.sv
// Panel buzzer tone generator: N_TONS one-hot selectable square-wave tones.
// Continuous mode follows the live selector while conta=1; timed mode plays a
// latched tone for DUR cycles, 1-15 times, after a one-cycle tocar pulse.
// Ports:
//   clock, reset (sync, active-high)
//   conta        in  continuous-mode enable (level)
//   tocar        in  start timed sequence (1-cycle pulse)
//   seletor      in  one-hot tone select, lowest set bit wins, 0 = silence
//   repeticoes   in  beep count for timed mode, 0 treated as 1
//   pulso        out square wave to the buzzer pin
//   ocupado      out high while a timed sequence runs
//   fim          out 1-cycle pulse when a timed sequence completes
// Config macro: BUZZER_PAUSA_EN inserts a silent DUR-cycle pause between beeps.
// Handshake: ocupado is high for every TOM/PAUSA cycle; fim is high only in the
// single FIM cycle that follows; tocar is accepted only while ocupado=0 and fim=0.
// The sequencer state is held in estado_q for external checkers.
module buzzer_multitom
  import buzzer_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned N_TONS     = 4,
  parameter int unsigned FREQ_BASE  = 500,
  parameter int unsigned DURACAO_MS = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              conta,
  input  logic              tocar,
  input  logic [N_TONS-1:0] seletor,
  input  logic [3:0]        repeticoes,
  output logic              pulso,
  output logic              ocupado,
  output logic              fim
);

  localparam int unsigned DUR_RAW = DURACAO_MS * (CLOCK_FREQ / 1000);
  localparam int unsigned DUR     = (DUR_RAW == 0) ? 1 : DUR_RAW;
  localparam int unsigned DW      = clog2_min1(DUR);
  localparam int unsigned IDXW    = clog2_min1(N_TONS);
  localparam int unsigned HPW     = clog2_min1(meio_periodo_calc(CLOCK_FREQ, FREQ_BASE, 0) + 1);
  localparam logic [DW-1:0] DUR_ULT = DW'(DUR - 1);

  // Half-period lookup, fixed at elaboration
  logic [HPW-1:0] hp_tab [N_TONS];
  for (genvar g = 0; g < N_TONS; g++) begin : g_hp
    assign hp_tab[g] = HPW'(meio_periodo_calc(CLOCK_FREQ, FREQ_BASE, g));
  end

  function automatic logic [IDXW-1:0] menor_bit(input logic [N_TONS-1:0] s);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = N_TONS - 1; i >= 0; i--) begin
      if (s[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  estado_t           estado_q, estado_d;
  logic [DW-1:0]     dur_q, dur_d;
  logic [3:0]        rep_q, rep_d;
  logic [N_TONS-1:0] lat_q, lat_d;
  logic              hab_q;
  logic [IDXW-1:0]   idx_q;

  logic              hab;
  logic              reinicia;
  logic [IDXW-1:0]   idx;
  logic [HPW-1:0]    hp_sel;

  always_comb begin
    estado_d = estado_q;
    dur_d    = dur_q;
    rep_d    = rep_q;
    lat_d    = lat_q;
    ocupado  = 1'b0;
    fim      = 1'b0;
    hab      = 1'b0;
    reinicia = 1'b0;
    idx      = '0;

    case (estado_q)
      OCIOSO: begin
        if (tocar) begin
          // hab stays low so the divider is cleared for the first beep
          lat_d    = seletor;
          rep_d    = (repeticoes == 4'd0) ? 4'd1 : repeticoes;
          dur_d    = '0;
          estado_d = TOM;
        end else if (conta) begin
          hab      = |seletor;
          idx      = menor_bit(seletor);
          // a different tone restarts the wave; silence->tone needs nothing
          // because the divider was already cleared while silent
          reinicia = hab && hab_q && (idx != idx_q);
        end
      end

      TOM: begin
        ocupado = 1'b1;
        idx     = menor_bit(lat_q);
        // dropping enable on the last cycle clears the divider so the next
        // beep (or pause / FIM) starts from counter 0, pulso 0
        hab     = (|lat_q) && (dur_q != DUR_ULT);
        if (dur_q == DUR_ULT) begin
          dur_d = '0;
          rep_d = rep_q - 4'd1;
          if (rep_q > 4'd1) begin
`ifdef BUZZER_PAUSA_EN
            estado_d = PAUSA;
`else
            estado_d = TOM;
`endif
          end else begin
            estado_d = FIM;
          end
        end else begin
          dur_d = dur_q + DW'(1);
        end
      end

`ifdef BUZZER_PAUSA_EN
      PAUSA: begin
        ocupado = 1'b1;
        if (dur_q == DUR_ULT) begin
          dur_d    = '0;
          estado_d = TOM;
        end else begin
          dur_d = dur_q + DW'(1);
        end
      end
`endif

      FIM: begin
        fim      = 1'b1;
        estado_d = OCIOSO;
      end

      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      dur_q    <= '0;
      rep_q    <= '0;
      lat_q    <= '0;
      hab_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      estado_q <= estado_d;
      dur_q    <= dur_d;
      rep_q    <= rep_d;
      lat_q    <= lat_d;
      hab_q    <= hab;
      idx_q    <= idx;
    end
  end

  assign hp_sel = hp_tab[idx];

  buzzer_divisor #(.W(HPW)) u_divisor (
    .clock        (clock),
    .reset        (reset),
    .habilita     (hab),
    .reinicia     (reinicia),
    .meio_periodo (hp_sel),
    .pulso        (pulso)
  );

endmodule

// File: tb/tb_buzzer_multitom.sv
// Self-checking bench for buzzer_multitom with a timeline-based reference model.
module tb_buzzer_multitom;

  localparam int CF  = 5000;
  localparam int NT  = 4;
  localparam int FB  = 250;
  localparam int DMS = 10;
  localparam int DUR = DMS * (CF / 1000);
`ifdef BUZZER_PAUSA_EN
  localparam bit COM_PAUSA = 1'b1;
`else
  localparam bit COM_PAUSA = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          conta;
  logic          tocar;
  logic [NT-1:0] seletor;
  logic [3:0]    repeticoes;
  logic          pulso;
  logic          ocupado;
  logic          fim;

  buzzer_multitom #(
    .CLOCK_FREQ (CF),
    .N_TONS     (NT),
    .FREQ_BASE  (FB),
    .DURACAO_MS (DMS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .conta      (conta),
    .tocar      (tocar),
    .seletor    (seletor),
    .repeticoes (repeticoes),
    .pulso      (pulso),
    .ocupado    (ocupado),
    .fim        (fim)
  );

  // clock/reset block
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // scoreboard: {pulso, ocupado, fim} expected after each edge
  logic [2:0] exp_q[$];

  // reference model state
  int hp[NT];
  bit m_ativo;
  int m_k;
  int m_total;
  int m_n;
  int m_prev;
  logic [NT-1:0] m_lat;

  function automatic int menor(input logic [NT-1:0] s);
    for (int i = 0; i < NT; i++) if (s[i]) return i;
    return -1;
  endfunction

  // One clock edge of the specified behaviour, written as a timeline:
  // k counts cycles since a timed sequence was accepted.
  task automatic modelo(input bit c, input bit t, input bit rst,
                        input logic [NT-1:0] s, input logic [3:0] r);
    int tt;
    int per;
    int off;
    int reps;
    logic ep;
    if (rst) begin
      m_ativo = 0; m_n = 0; m_prev = -1;
      exp_q.push_back(3'b000);
    end else if (m_ativo) begin
      m_k++;
      if (m_k == m_total + 2) begin
        m_ativo = 0; m_n = 0; m_prev = -1;
        exp_q.push_back(3'b000);
      end else if (m_k == m_total + 1) begin
        exp_q.push_back(3'b001);
      end else begin
        per = COM_PAUSA ? 2 * DUR : DUR;
        off = (m_k - 1) % per;
        tt  = menor(m_lat);
        ep  = (off < DUR && tt >= 0) ? 1'((off / hp[tt]) % 2) : 1'b0;
        exp_q.push_back({ep, 1'b1, 1'b0});
      end
    end else if (t) begin
      reps    = (r == 0) ? 1 : int'(r);
      m_ativo = 1;
      m_k     = 1;
      m_lat   = s;
      m_total = COM_PAUSA ? (2 * reps - 1) * DUR : reps * DUR;
      m_n     = 0;
      m_prev  = -1;
      exp_q.push_back(3'b010);
    end else if (c && menor(s) >= 0) begin
      tt = menor(s);
      if (m_prev >= 0 && tt != m_prev) m_n = 0;
      else m_n++;
      m_prev = tt;
      exp_q.push_back({1'((m_n / hp[tt]) % 2), 2'b00});
    end else begin
      m_n = 0; m_prev = -1;
      exp_q.push_back(3'b000);
    end
  endtask

  task automatic conferir(input string tag);
    logic [2:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (pulso === e[2]) else begin
      errors++;
      $error("FAIL %s pulso observed=%b expected=%b t=%0t", tag, pulso, e[2], $time);
    end
    checks++;
    assert (ocupado === e[1]) else begin
      errors++;
      $error("FAIL %s ocupado observed=%b expected=%b t=%0t", tag, ocupado, e[1], $time);
    end
    checks++;
    assert (fim === e[0]) else begin
      errors++;
      $error("FAIL %s fim observed=%b expected=%b t=%0t", tag, fim, e[0], $time);
    end
  endtask

  // driver: apply inputs, clock one edge, check #1 later, return at negedge
  task automatic ciclo(input bit c, input bit t, input bit rst,
                       input logic [NT-1:0] s, input logic [3:0] r, input string tag);
    conta = c; tocar = t; reset = rst; seletor = s; repeticoes = r;
    @(posedge clock);
    modelo(c, t, rst, s, r);
    #1;
    conferir(tag);
    @(negedge clock);
  endtask

  task automatic repete(input int n, input bit c, input logic [NT-1:0] s, input string tag);
    for (int i = 0; i < n; i++) ciclo(c, 1'b0, 1'b0, s, 4'd1, tag);
  endtask

  initial begin
    for (int i = 0; i < NT; i++) begin
      hp[i] = CF / (2 * FB * (i + 1));
      if (hp[i] < 1) hp[i] = 1;
    end
    m_ativo = 0; m_k = 0; m_total = 0; m_n = 0; m_prev = -1; m_lat = '0;

    // reset wins over conta, then one cycle after release
    for (int i = 0; i < 3; i++) ciclo(1'b1, 1'b0, 1'b1, 4'b0001, 4'd1, "reset");
    ciclo(1'b1, 1'b0, 1'b0, 4'b0001, 4'd1, "pos_reset");

    // continuous tones: slowest, then switch to fastest
    repete(44, 1'b1, 4'b0001, "cont_hp10");
    repete(12, 1'b1, 4'b1000, "cont_hp2");
    // multi-bit select: lowest bit wins, then silence
    repete(20, 1'b1, 4'b0110, "cont_lowbit");
    repete(5, 1'b1, 4'b0000, "cont_silencio");
    repete(5, 1'b0, 4'b0010, "conta_off");

    // timed, 2 reps on tone 2; selector and conta churn mid-run
    ciclo(1'b0, 1'b1, 1'b0, 4'b0100, 4'd2, "tocar_2");
    for (int i = 0; i < 160; i++)
      ciclo(1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'd2, "seq_2");

    // repeticoes=0 behaves as one beep; tocar during ocupado ignored
    ciclo(1'b0, 1'b1, 1'b0, 4'b0010, 4'd0, "tocar_0");
    for (int i = 0; i < 60; i++)
      ciclo(1'b0, (i == 10 || i == 25), 1'b0, 4'b1000, 4'd5, "seq_0");

    // reset during a beep aborts without fim
    ciclo(1'b0, 1'b1, 1'b0, 4'b0001, 4'd3, "tocar_3");
    repete(29, 1'b0, 4'b0001, "seq_3");
    ciclo(1'b0, 1'b0, 1'b1, 4'b0001, 4'd3, "reset_meio");
    repete(10, 1'b0, 4'b0001, "pos_abort");

    // randomized mix of both modes
    for (int i = 0; i < 900; i++)
      ciclo(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 399) == 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 3)), "aleatorio");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
